path_writeback: RTL and testbench
=================================

Name: path_writeback

Overview:
- Downstream consumer of the visited store's predecessor vector (`prev_vector_flattened`).
- After the search completes, walks predecessors from a destination node back to the source and writes the node indices to memory through the shared write port.
- Reports the path length and an error code, then returns to idle.

Parameters:
- MAX_NODES, `DEFAULT_MAX_NODES, number of node slots in the predecessor vector
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH, width of one node index
- MADDR_WIDTH, `DEFAULT_MADDR_WIDTH, memory address width
- MDATA_WIDTH, `DEFAULT_MDATA_WIDTH, memory data width (must be >= INDEX_WIDTH)

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; ignored while busy=1
- number_of_nodes  in  INDEX_WIDTH  active node count
- source_node  in  INDEX_WIDTH  search root
- dest_node  in  INDEX_WIDTH  path endpoint
- out_base_address  in  MADDR_WIDTH  first output word address
- prev_vector_flattened  in  INDEX_WIDTH*MAX_NODES  predecessor of node j at bits [INDEX_WIDTH*j +: INDEX_WIDTH]
- mem_write_enable  out  1  write request
- mem_addr  out  MADDR_WIDTH  write address
- mem_write_data  out  MDATA_WIDTH  node index, zero-extended
- mem_write_ready  in  1  write accepted this cycle
- busy  out  1  walk in progress
- done  out  1  one-cycle completion pulse
- path_length  out  INDEX_WIDTH+1  nodes written; valid while done=1, held until next start
- error_code  out  2  0 OK, 1 BAD_INDEX, 2 NO_PATH, 3 LOOP; valid with done

Behaviour:
- Reset values: mem_write_enable=0, busy=0, done=0, mem_addr=0, mem_write_data=0, path_length=0, error_code=0, state=IDLE. A reset in any state aborts the walk; no further writes are issued.
- start, source_node, dest_node, out_base_address and number_of_nodes are latched on the accepted start cycle. The prev vector is sampled live and must stay stable while busy=1.
- Root marker: prev[i]==i. The source is its own predecessor. Any other self-looped node is unreachable.
- States:
  - IDLE: on start, check the latched inputs. If dest_node or source_node >= number_of_nodes, go to DONE with error 1 and issue no writes. Otherwise set cur=dest and hop=0, and go to WRITE (or COUNT when the optional feature is enabled). busy rises the cycle after start.
  - WRITE:
    - Drive mem_write_enable=1, mem_write_data=cur, mem_addr=base+offset. These are held stable until mem_write_ready is sampled high at a posedge.
    - On acceptance: hop++.
      - If cur==source, go to DONE with error 0 and path_length=hop.
      - Else if prev[cur]==cur, go to DONE with error 2.
      - Else if prev[cur] >= number_of_nodes, go to DONE with error 1.
      - Else if hop == number_of_nodes, go to DONE with error 3.
      - Else cur=prev[cur].
    - mem_write_enable drops the cycle after the last acceptance.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE. path_length = number of writes actually accepted, including on error.
- Throughput: one write per cycle when mem_write_ready is tied high.
- Address arithmetic: offset is modulo 2**MADDR_WIDTH; wrap-around past the top of memory is permitted and not flagged.
- dest==source: exactly one write (the source index), path_length=1, error 0.
- start asserted in the same cycle as done: ignored. It is accepted only in IDLE.

Optional Feature:
- Macro: PATH_REVERSE_EN.
- Without it: the walk writes destination-first, offset = hop.
- With it:
  - A COUNT state runs before WRITE and follows prev one node per cycle, with no memory traffic, to compute length L using the same error checks. On error, COUNT goes straight to DONE with zero writes.
  - WRITE then re-walks from dest with offset = L-1-hop, so memory holds the path source-first.
  - Added latency: L cycles.

Decomposition:
- Shared package (alongside the existing constants): error-code enum {ERR_OK, ERR_BAD_INDEX, ERR_NO_PATH, ERR_LOOP}, state enum {PW_IDLE, PW_COUNT, PW_WRITE, PW_DONE}, and a function extracting prev[j] from the flattened vector.
- One sub-module: `prev_lookup` (combinational mux from the flattened vector, index to predecessor). It is reusable by the top-level controller.

Test Plan:
- N=5, prev={0,0,1,2,3}, src=0, dest=4, base=0x100, ready=1 -> writes 4,3,2,1,0 at 0x100..0x104 on consecutive cycles; done, length=5, err=0.
- Same setup with ready toggling 1-of-3 cycles -> identical write sequence, addr/data stable while waiting, no duplicate writes.
- N=4, prev={0,0,2,1}, dest=2 -> one write (2 at base), done, length=1, err=2.
- N=4, prev={0,2,1,1}, src=0, dest=3 -> writes 3,1,2,1 then err=3, length=4; dest=6 with N=4 -> zero writes, err=1.
- Reset asserted during the third write of scenario 1 -> all outputs return to reset values next cycle; a new start runs the full path cleanly.
- PATH_REVERSE_EN build, scenario 1 -> 5 idle cycles, then data 4,3,2,1,0 at addresses 0x104..0x100, so memory reads 0,1,2,3,4 ascending.

Source files
------------

// File: rtl/path_writeback_pkg.sv
// Shared types and default geometry for the predecessor-path writeback block.
// Holds the state/error encodings and a flattened-vector predecessor extractor.
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 12
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 16
`endif

package path_writeback_pkg;

    localparam int PW_MAX_NODES   = `DEFAULT_MAX_NODES;
    localparam int PW_INDEX_WIDTH = `DEFAULT_INDEX_WIDTH;
    localparam int PW_MADDR_WIDTH = `DEFAULT_MADDR_WIDTH;
    localparam int PW_MDATA_WIDTH = `DEFAULT_MDATA_WIDTH;

    typedef enum logic [1:0] {
        ERR_OK        = 2'd0,
        ERR_BAD_INDEX = 2'd1,
        ERR_NO_PATH   = 2'd2,
        ERR_LOOP      = 2'd3
    } pw_err_e;

    typedef enum logic [1:0] {
        PW_IDLE  = 2'd0,
        PW_COUNT = 2'd1,
        PW_WRITE = 2'd2,
        PW_DONE  = 2'd3
    } pw_state_e;

    // Predecessor of node j for the default geometry; out-of-range j reads as 0.
    function automatic logic [PW_INDEX_WIDTH-1:0] pw_prev_of(
        input logic [PW_INDEX_WIDTH*PW_MAX_NODES-1:0] flat,
        input logic [PW_INDEX_WIDTH-1:0]              j
    );
        logic [PW_INDEX_WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < PW_MAX_NODES; k++) begin
            if (j == PW_INDEX_WIDTH'(k)) begin
                r = flat[k*PW_INDEX_WIDTH +: PW_INDEX_WIDTH];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/path_writeback_prev_lookup.sv
// Combinational predecessor mux: index -> prev[index] from the flattened vector.
// Zero latency, no flow control; indices beyond MAX_NODES read as 0.
module prev_lookup #(
    parameter int MAX_NODES   = 8,
    parameter int INDEX_WIDTH = 4
) (
    input  logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_i,
    input  logic [INDEX_WIDTH-1:0]           index_i,
    output logic [INDEX_WIDTH-1:0]           pred_o
);

    always_comb begin
        pred_o = '0;
        for (int j = 0; j < MAX_NODES; j++) begin
            if (index_i == INDEX_WIDTH'(j)) begin
                pred_o = prev_vector_i[j*INDEX_WIDTH +: INDEX_WIDTH];
            end
        end
    end

endmodule

// File: rtl/path_writeback.sv
// Walks predecessors dest->source, one memory write per accepted cycle, then pulses done.
// Writes hold until mem_write_ready; PATH_REVERSE_EN adds a COUNT pass so memory is source-first.
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 12
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 16
`endif

module path_writeback
    import path_writeback_pkg::*;
#(
    parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
    parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [INDEX_WIDTH-1:0]           number_of_nodes,
    input  logic [INDEX_WIDTH-1:0]           source_node,
    input  logic [INDEX_WIDTH-1:0]           dest_node,
    input  logic [MADDR_WIDTH-1:0]           out_base_address,
    input  logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_flattened,
    output logic                             mem_write_enable,
    output logic [MADDR_WIDTH-1:0]           mem_addr,
    output logic [MDATA_WIDTH-1:0]           mem_write_data,
    input  logic                             mem_write_ready,
    output logic                             busy,
    output logic                             done,
    output logic [INDEX_WIDTH:0]             path_length,
    output logic [1:0]                       error_code
);

    pw_state_e              state_q, state_d;
    pw_err_e                err_q, err_d;
    logic [INDEX_WIDTH-1:0] cur_q, cur_d;
    logic [INDEX_WIDTH-1:0] nn_q, nn_d;
    logic [INDEX_WIDTH-1:0] src_q, src_d;
    logic [MADDR_WIDTH-1:0] base_q, base_d;
    logic [INDEX_WIDTH:0]   hop_q, hop_d;
    logic [INDEX_WIDTH:0]   plen_q, plen_d;
`ifdef PATH_REVERSE_EN
    logic [INDEX_WIDTH-1:0] dst_q, dst_d;
    logic [INDEX_WIDTH:0]   rlen_q, rlen_d;
`endif

    logic [INDEX_WIDTH-1:0] prev_cur;
    logic [INDEX_WIDTH:0]   hop_inc;
    logic                   step_end;
    pw_err_e                step_err;
    logic [MADDR_WIDTH-1:0] offset;

    prev_lookup #(
        .MAX_NODES   (MAX_NODES),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_prev_lookup (
        .prev_vector_i (prev_vector_flattened),
        .index_i       (cur_q),
        .pred_o        (prev_cur)
    );

    assign hop_inc = hop_q + {{INDEX_WIDTH{1'b0}}, 1'b1};

    // One hop of the walk: decide whether the current node ends the path and why.
    always_comb begin
        step_end = 1'b1;
        step_err = ERR_OK;
        if (cur_q == src_q) begin
            step_err = ERR_OK;
        end else if (prev_cur == cur_q) begin
            step_err = ERR_NO_PATH;
        end else if (prev_cur >= nn_q) begin
            step_err = ERR_BAD_INDEX;
        end else if (hop_inc == {1'b0, nn_q}) begin
            step_err = ERR_LOOP;
        end else begin
            step_end = 1'b0;
        end
    end

`ifdef PATH_REVERSE_EN
    assign offset = MADDR_WIDTH'(rlen_q - hop_q - {{INDEX_WIDTH{1'b0}}, 1'b1});
`else
    assign offset = MADDR_WIDTH'(hop_q);
`endif

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cur_d   = cur_q;
        nn_d    = nn_q;
        src_d   = src_q;
        base_d  = base_q;
        hop_d   = hop_q;
        plen_d  = plen_q;
`ifdef PATH_REVERSE_EN
        dst_d   = dst_q;
        rlen_d  = rlen_q;
`endif
        case (state_q)
            PW_IDLE: begin
                if (start) begin
                    nn_d   = number_of_nodes;
                    src_d  = source_node;
                    base_d = out_base_address;
                    cur_d  = dest_node;
                    hop_d  = '0;
                    plen_d = '0;
                    err_d  = ERR_OK;
`ifdef PATH_REVERSE_EN
                    dst_d  = dest_node;
`endif
                    if ((dest_node >= number_of_nodes) || (source_node >= number_of_nodes)) begin
                        err_d   = ERR_BAD_INDEX;
                        state_d = PW_DONE;
                    end else begin
`ifdef PATH_REVERSE_EN
                        state_d = PW_COUNT;
`else
                        state_d = PW_WRITE;
`endif
                    end
                end
            end
            PW_COUNT: begin
`ifdef PATH_REVERSE_EN
                // Dry walk: same hop rules as WRITE, but only the length is kept.
                hop_d = hop_inc;
                if (step_end && (step_err == ERR_OK)) begin
                    rlen_d  = hop_inc;
                    cur_d   = dst_q;
                    hop_d   = '0;
                    state_d = PW_WRITE;
                end else if (step_end) begin
                    err_d   = step_err;
                    plen_d  = '0;
                    state_d = PW_DONE;
                end else begin
                    cur_d = prev_cur;
                end
`else
                state_d = PW_IDLE;
`endif
            end
            PW_WRITE: begin
                if (mem_write_ready) begin
                    hop_d = hop_inc;
                    if (step_end) begin
                        err_d   = step_err;
                        plen_d  = hop_inc;
                        state_d = PW_DONE;
                    end else begin
                        cur_d = prev_cur;
                    end
                end
            end
            PW_DONE: begin
                state_d = PW_IDLE;
            end
            default: begin
                state_d = PW_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= PW_IDLE;
            err_q   <= ERR_OK;
            cur_q   <= '0;
            nn_q    <= '0;
            src_q   <= '0;
            base_q  <= '0;
            hop_q   <= '0;
            plen_q  <= '0;
`ifdef PATH_REVERSE_EN
            dst_q   <= '0;
            rlen_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cur_q   <= cur_d;
            nn_q    <= nn_d;
            src_q   <= src_d;
            base_q  <= base_d;
            hop_q   <= hop_d;
            plen_q  <= plen_d;
`ifdef PATH_REVERSE_EN
            dst_q   <= dst_d;
            rlen_q  <= rlen_d;
`endif
        end
    end

    // Outputs decode straight from registered state, so they are glitch-free and zero outside WRITE.
    assign mem_write_enable = (state_q == PW_WRITE);
    assign mem_addr         = mem_write_enable ? (base_q + offset) : '0;
    assign mem_write_data   = mem_write_enable ? MDATA_WIDTH'(cur_q) : '0;
    assign busy             = (state_q == PW_WRITE) || (state_q == PW_COUNT);
    assign done             = (state_q == PW_DONE);
    assign path_length      = plen_q;
    assign error_code       = err_q;

endmodule

// File: tb/tb_path_writeback.sv
// Directed and randomized walks of path_writeback checked against a list-based path model.
module tb_path_writeback;

    localparam int MN = 8;
    localparam int IW = 4;
    localparam int MA = 12;
    localparam int MD = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [IW-1:0]    number_of_nodes;
    logic [IW-1:0]    source_node;
    logic [IW-1:0]    dest_node;
    logic [MA-1:0]    out_base_address;
    logic [IW*MN-1:0] prev_vector_flattened;
    logic             mem_write_enable;
    logic [MA-1:0]    mem_addr;
    logic [MD-1:0]    mem_write_data;
    logic             mem_write_ready;
    logic             busy;
    logic             done;
    logic [IW:0]      path_length;
    logic [1:0]       error_code;

    logic [IW-1:0]    prev_a [MN];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    always_comb begin
        prev_vector_flattened = '0;
        for (int j = 0; j < MN; j++) prev_vector_flattened[j*IW +: IW] = prev_a[j];
    end

    path_writeback #(
        .MAX_NODES   (MN),
        .INDEX_WIDTH (IW),
        .MADDR_WIDTH (MA),
        .MDATA_WIDTH (MD)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .start                 (start),
        .number_of_nodes       (number_of_nodes),
        .source_node           (source_node),
        .dest_node             (dest_node),
        .out_base_address      (out_base_address),
        .prev_vector_flattened (prev_vector_flattened),
        .mem_write_enable      (mem_write_enable),
        .mem_addr              (mem_addr),
        .mem_write_data        (mem_write_data),
        .mem_write_ready       (mem_write_ready),
        .busy                  (busy),
        .done                  (done),
        .path_length           (path_length),
        .error_code            (error_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // rmode: 0 ready always, 1 ready one cycle in three, 2 random ready.
    task automatic run_walk(input int n, input int src, input int dst, input int base,
                            input int rmode, input bit start_on_done, input int reset_at);
        int exp_path[$];
        int got_d[$];
        int got_a[$];
        int got_k[$];
        int m, nw, k, done_k, eerr, cur, p, exp_done, ea;
        bit bad_idx, waiting;
        logic [MA-1:0] last_a;
        logic [MD-1:0] last_d;
        logic [IW:0]   got_len;
        logic [1:0]    got_err;

        // Reference: follow the predecessor list until the source or a rule stops it.
        eerr    = 0;
        bad_idx = (src >= n) || (dst >= n);
        if (bad_idx) begin
            eerr = 1;
        end else begin
            cur = dst;
            while (1) begin
                exp_path.push_back(cur);
                if (cur == src) break;
                p = int'(prev_a[cur]);
                if (p == cur) begin eerr = 2; break; end
                if (p >= n) begin eerr = 1; break; end
                if (exp_path.size() == n) begin eerr = 3; break; end
                cur = p;
            end
        end
        m = exp_path.size();
`ifdef PATH_REVERSE_EN
        nw       = (eerr == 0) ? m : 0;
        exp_done = 1 + m + nw;
`else
        nw       = m;
        exp_done = 1 + m;
`endif

        @(negedge clock);
        number_of_nodes  = IW'(n);
        source_node      = IW'(src);
        dest_node        = IW'(dst);
        out_base_address = MA'(base);
        start            = 1'b1;
        k       = 0;
        done_k  = -1;
        waiting = 1'b0;
        last_a  = '0;
        last_d  = '0;
        got_len = '0;
        got_err = '0;
        while (done_k < 0 && k < 200) begin
            @(negedge clock);
            k++;
            start = 1'b0;
            case (rmode)
                0:       mem_write_ready = 1'b1;
                1:       mem_write_ready = ((k % 3) == 0);
                default: mem_write_ready = 1'($urandom_range(0, 1));
            endcase
            if (k == reset_at) begin
                reset = 1'b1;
                @(negedge clock);
                chk("reset_abort_outputs",
                    {mem_write_enable, mem_addr, mem_write_data, busy, done, path_length, error_code}, 0);
                reset = 1'b0;
                return;
            end
            if (k == 1) chk("busy_after_start", busy, !bad_idx);
            if (waiting) begin
                chk("hold_we", mem_write_enable, 1);
                chk("hold_addr", mem_addr, last_a);
                chk("hold_data", mem_write_data, last_d);
            end
            if (mem_write_enable && mem_write_ready) begin
                got_d.push_back(int'(mem_write_data));
                got_a.push_back(int'(mem_addr));
                got_k.push_back(k);
            end
            waiting = mem_write_enable && !mem_write_ready;
            last_a  = mem_addr;
            last_d  = mem_write_data;
            if (done) begin
                done_k  = k;
                got_len = path_length;
                got_err = error_code;
                chk("busy_low_at_done", busy, 0);
                if (start_on_done) start = 1'b1;
            end
        end

        chk("done_seen", done_k > 0, 1);
        chk("write_count", got_d.size(), nw);
        for (int i = 0; i < got_d.size() && i < nw; i++) begin
`ifdef PATH_REVERSE_EN
            ea = (base + m - 1 - i) % (1 << MA);
`else
            ea = (base + i) % (1 << MA);
`endif
            chk("write_data", got_d[i], exp_path[i]);
            chk("write_addr", got_a[i], ea);
            if (rmode == 0) chk("write_cycle", got_k[i], exp_done - nw + i);
        end
        if (done_k > 0) begin
            chk("path_length", got_len, nw);
            chk("error_code", got_err, eerr);
            if (rmode == 0) chk("done_cycle", done_k, exp_done);
        end
        if (start_on_done) begin
            @(negedge clock);
            start = 1'b0;
            repeat (3) begin
                @(negedge clock);
                chk("start_on_done_ignored", {mem_write_enable, busy, done}, 0);
            end
            chk("length_held", path_length, nw);
        end
    endtask

    initial begin
        reset            = 1'b1;
        start            = 1'b0;
        number_of_nodes  = '0;
        source_node      = '0;
        dest_node        = '0;
        out_base_address = '0;
        mem_write_ready  = 1'b1;
        prev_a           = '{0, 0, 0, 0, 0, 0, 0, 0};
        repeat (3) @(negedge clock);
        chk("reset_we_busy_done", {mem_write_enable, busy, done}, 0);
        chk("reset_addr_data", {mem_addr, mem_write_data}, 0);
        chk("reset_len_err", {path_length, error_code}, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_after_reset", {mem_write_enable, busy, done}, 0);

        // Straight chain, full speed then throttled.
        prev_a = '{0, 0, 1, 2, 3, 0, 0, 0};
        run_walk(5, 0, 4, 'h100, 0, 1'b0, 0);
        run_walk(5, 0, 4, 'h100, 1, 1'b0, 0);

        // Unreachable destination (self-looped, not the source).
        prev_a = '{0, 0, 2, 1, 0, 0, 0, 0};
        run_walk(4, 0, 2, 'h040, 0, 1'b0, 0);

        // Cycle not containing the source, then an out-of-range destination.
        prev_a = '{0, 2, 1, 1, 0, 0, 0, 0};
        run_walk(4, 0, 3, 'h200, 0, 1'b0, 0);
        run_walk(4, 0, 6, 'h200, 0, 1'b0, 0);

        // dest == source, and address wrap past the top of memory.
        prev_a = '{0, 0, 1, 2, 3, 0, 0, 0};
        run_walk(5, 2, 2, 'h010, 0, 1'b0, 0);
        run_walk(5, 0, 4, 'hFFE, 0, 1'b0, 0);

        // Reset mid-walk, then a clean rerun; start coincident with done.
        run_walk(5, 0, 4, 'h100, 0, 1'b0, 3);
        repeat (3) begin
            @(negedge clock);
            chk("quiet_after_reset", {mem_write_enable, busy, done}, 0);
        end
        run_walk(5, 0, 4, 'h100, 0, 1'b0, 0);
        run_walk(5, 0, 4, 'h100, 0, 1'b1, 0);

        for (int t = 0; t < 40; t++) begin
            int n, s, d;
            n = $urandom_range(1, MN);
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < MN; j++) prev_a[j] = (j == 0) ? 4'd0 : IW'($urandom_range(0, j - 1));
                s = 0;
            end else begin
                for (int j = 0; j < MN; j++) prev_a[j] = IW'($urandom_range(0, n));
                s = $urandom_range(0, n - 1);
                if ($urandom_range(0, 9) == 0) s = n;
            end
            d = $urandom_range(0, n);
            run_walk(n, s, d, $urandom_range(0, (1 << MA) - 1), $urandom_range(0, 2), 1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
